// File: rtl/poly_adsr.sv
// poly_adsr: time-multiplexed ADSR envelope generator.
// One shared datapath walks channels 0..NCH-1 once per accepted sample tick.
// Each channel is read in one cycle and written back, with its level
// presented on out/out_ch, in the next cycle.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   ena            sample tick; starts a scan when not busy
//   gate[NCH]      per-channel gate, sampled in that channel's read cycle
//   retrig         1: restart attack from zero on re-gate during release
//   A, D, R        attack / decay / release rates
//   S              sustain level
//   out, out_ch    envelope level and its channel index
//   out_valid      out/out_ch valid this cycle
//   busy           scan in progress
//
// Optional feature: define ADSR_EXP_RELEASE_EN for an exponential-like
// release (step = rel + acc>>8, saturating); otherwise release is linear.
module poly_adsr #(
  parameter int NCH    = 8,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 18,
  parameter int RATE_W = 14,
  localparam int CW    = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NCH-1:0]    gate,
  input  logic              retrig,
  input  logic [RATE_W-1:0] A,
  input  logic [RATE_W-1:0] D,
  input  logic [RATE_W-1:0] R,
  input  logic [OUT_W-1:0]  S,
  output logic [OUT_W-1:0]  out,
  output logic [CW-1:0]     out_ch,
  output logic              out_valid,
  output logic              busy
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, ATTACK = 3'd1, DECAY = 3'd2, SUSTAIN = 3'd3, RELEASE = 3'd4
  } st_e;

  // All envelope arithmetic is one bit wider than acc so sums/compares never wrap.
  localparam int XW = ACC_W + 1;
  localparam logic [XW-1:0] MAXV = {2'b00, {(ACC_W-1){1'b1}}};

  st_e              st_q  [NCH];
  logic [ACC_W-1:0] acc_q [NCH];
  logic [1:0]       vld_pipe;   // [0] read stage active, [1] output stage
  logic [CW-1:0]    rd_ch;

  st_e              st_r, st_n;
  logic [ACC_W-1:0] acc_n;
  logic [XW-1:0]    acc_x, inc_x, dec_x, rel_x, sus_x, sum_x, dif_x, stp_x, rdf_x;
  logic             g;

  assign busy      = |vld_pipe;
  assign out_valid = vld_pipe[1];

  assign st_r  = st_q[rd_ch];
  assign acc_x = {1'b0, acc_q[rd_ch]};
  assign g     = gate[rd_ch];
  assign inc_x = {{(XW-RATE_W-4){1'b0}}, A, 4'b0};
  assign dec_x = {{(XW-RATE_W-4){1'b0}}, D, 4'b0};
  assign rel_x = {{(XW-RATE_W-4){1'b0}}, R, 4'b0};
  assign sus_x = {2'b00, S, {(ACC_W-1-OUT_W){1'b0}}};
  assign sum_x = acc_x + inc_x;
  assign dif_x = acc_x - dec_x;

`ifdef ADSR_EXP_RELEASE_EN
  logic [XW-1:0] exp_x;
  assign exp_x = rel_x + (acc_x >> 8);
  // Clamp to the largest ACC_W-bit value.
  assign stp_x = exp_x[ACC_W] ? {1'b0, {ACC_W{1'b1}}} : exp_x;
`else
  assign stp_x = rel_x;
`endif
  assign rdf_x = acc_x - stp_x;

  always_comb begin
    st_n  = st_r;
    acc_n = acc_x[ACC_W-1:0];
    case (st_r)
      IDLE:    if (g) st_n = ATTACK;
      ATTACK:
        if (!g) st_n = RELEASE;
        else if (sum_x > MAXV) begin
          acc_n = MAXV[ACC_W-1:0];
          st_n  = DECAY;
        end else acc_n = sum_x[ACC_W-1:0];
      DECAY:
        if (!g) st_n = RELEASE;
        // acc >= dec guards the subtraction so underflow never looks "greater".
        else if (acc_x >= dec_x && dif_x > sus_x) acc_n = dif_x[ACC_W-1:0];
        else begin
          acc_n = sus_x[ACC_W-1:0];
          st_n  = SUSTAIN;
        end
      SUSTAIN:
        if (!g) st_n = RELEASE;
        else acc_n = sus_x[ACC_W-1:0];
      RELEASE:
        if (g) begin
          st_n = ATTACK;
          if (retrig) acc_n = '0;
        end else if (acc_x > stp_x) acc_n = rdf_x[ACC_W-1:0];
        else begin
          acc_n = '0;
          st_n  = IDLE;
        end
      default: begin
        st_n  = IDLE;
        acc_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]  <= IDLE;
        acc_q[i] <= '0;
      end
      vld_pipe <= '0;
      rd_ch    <= '0;
      out      <= '0;
      out_ch   <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        st_q[rd_ch]  <= st_n;
        acc_q[rd_ch] <= acc_n;
        out          <= acc_n[ACC_W-2 -: OUT_W];
        out_ch       <= rd_ch;
        rd_ch        <= rd_ch + 1'b1;
        if (rd_ch == CW'(NCH-1)) vld_pipe[0] <= 1'b0;
      end else if (ena && !busy) begin
        vld_pipe[0] <= 1'b1;
        rd_ch       <= '0;
      end
    end
  end
endmodule

// File: tb/tb_poly_adsr.sv
module tb_poly_adsr;
  localparam int NCH = 4, ACC_W = 32, OUT_W = 18, RATE_W = 14;
  localparam longint MAXV = 64'h7FFF_FFFF;

  logic              clk = 1'b0;
  logic              rst_n, ena, retrig;
  logic [NCH-1:0]    gate;
  logic [RATE_W-1:0] A, D, R;
  logic [OUT_W-1:0]  S;
  logic [OUT_W-1:0]  out;
  logic [1:0]        out_ch;
  logic              out_valid, busy;

  poly_adsr #(.NCH(NCH), .ACC_W(ACC_W), .OUT_W(OUT_W), .RATE_W(RATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .gate(gate), .retrig(retrig),
    .A(A), .D(D), .R(R), .S(S),
    .out(out), .out_ch(out_ch), .out_valid(out_valid), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct { int ch; longint lvl; longint cyc; } exp_t;
  exp_t   q[$];
  int     checks = 0, failures = 0;
  longint cyc = 0, busy_last = -1;
  bit     rst_seen = 1'b0;

  // Reference envelope: state 0..4 = idle/attack/decay/sustain/release.
  int     mst [NCH];
  longint macc[NCH];

  function automatic void model_chan(input int c);
    longint inc, dec, step, sus;
    inc = longint'(A) * 16;
    dec = longint'(D) * 16;
    sus = longint'(S) * 8192;
    step = longint'(R) * 16;
`ifdef ADSR_EXP_RELEASE_EN
    step = step + macc[c] / 256;
    if (step > 64'hFFFF_FFFF) step = 64'hFFFF_FFFF;
`endif
    case (mst[c])
      0: if (gate[c]) mst[c] = 1;
      1: if (!gate[c]) mst[c] = 4;
         else if (macc[c] + inc > MAXV) begin macc[c] = MAXV; mst[c] = 2; end
         else macc[c] = macc[c] + inc;
      2: if (!gate[c]) mst[c] = 4;
         else if (macc[c] - dec > sus) macc[c] = macc[c] - dec;
         else begin macc[c] = sus; mst[c] = 3; end
      3: if (!gate[c]) mst[c] = 4;
         else macc[c] = sus;
      default:
         if (gate[c]) begin mst[c] = 1; if (retrig) macc[c] = 0; end
         else if (macc[c] > step) macc[c] = macc[c] - step;
         else begin macc[c] = 0; mst[c] = 0; end
    endcase
  endfunction

  // Protocol model: accepts a tick only when the previous scan is over and
  // queues the expected (channel, level, cycle) stream.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin mst[c] = 0; macc[c] = 0; end
      q.delete();
      busy_last = -1;
      rst_seen  = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (ena && (cyc - 1 > busy_last)) begin
        for (int c = 0; c < NCH; c++) begin
          exp_t e;
          model_chan(c);
          e.ch = c; e.lvl = (macc[c] >> 13) & 64'h3FFFF; e.cyc = cyc + 1 + c;
          q.push_back(e);
        end
        busy_last = cyc + NCH;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (rst_seen) begin
      checks++;
      if (out !== '0 || out_ch !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset: out=%h ch=%0d vld=%b busy=%b, required all zero",
                 out, out_ch, out_valid, busy);
      end
    end else begin
      checks++;
      if (busy !== (cyc <= busy_last)) begin
        failures++;
        $display("FAIL busy @%0d: got %b required %b", cyc, busy, cyc <= busy_last);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid @%0d: ch=%0d out=%h with nothing expected", cyc, out_ch, out);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (out_ch !== 2'(e.ch) || out !== 18'(e.lvl) || e.cyc != cyc) begin
            failures++;
            $display("FAIL output @%0d: ch=%0d out=%h, required ch=%0d out=%h @%0d",
                     cyc, out_ch, out, e.ch, e.lvl, e.cyc);
          end
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++; failures++;
        $display("FAIL missing_valid @%0d: got out_valid=0, required ch=%0d out=%h", cyc, e.ch, e.lvl);
      end
    end
  end

  // One sample tick: ena for a cycle, optional second ena two cycles later
  // (must be ignored), optional two-cycle reset in the middle of the scan.
  task automatic scan(input int period, input bit extra, input bit rstp);
    ena = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i < period; i++) begin
      ena   = extra && (i == 2);
      rst_n = !(rstp && (i == 3 || i == 4));
      @(posedge clk); #1;
    end
    ena = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; gate = '0; retrig = 1'b0;
    A = '0; D = '0; R = '0; S = '0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1; ena = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Back-to-back ena pulse: only one scan.
    gate = 4'b0001; A = 14'h3FFF; D = 14'h3FFF; R = 14'h3FFF; S = 18'h3F000; retrig = 1'b1;
    scan(6, 1'b1, 1'b0);
    // Full attack to MAX, into decay, then sustain.
    repeat (8200) scan(6, 1'b0, 1'b0);
    repeat (140) scan(6, 1'b0, 1'b0);
    S = 18'h3E000;
    repeat (3) scan(6, 1'b0, 1'b0);
    gate = 4'b0000;
    scan(6, 1'b0, 1'b0);
    gate = 4'b0001;
    scan(6, 1'b0, 1'b0);

    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 3) == 0) gate = 4'($urandom);
      if ($urandom_range(0, 7) == 0) A = ($urandom_range(0, 3) == 0) ? '0 : 14'($urandom_range(1, 16383));
      if ($urandom_range(0, 7) == 0) D = ($urandom_range(0, 3) == 0) ? '0 : 14'($urandom_range(1, 16383));
      if ($urandom_range(0, 7) == 0) R = ($urandom_range(0, 3) == 0) ? '0 : 14'($urandom_range(1, 16383));
      if ($urandom_range(0, 7) == 0) S = 18'($urandom);
      if ($urandom_range(0, 5) == 0) retrig = ~retrig;
      scan($urandom_range(6, 14), $urandom_range(0, 7) == 0, n == 350);
    end

    repeat (10) begin @(posedge clk); #1; end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected outputs never appeared, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
